// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and IF/ID signals of the fetch stage.
interface fetch_unit_if;
  logic [15:0] instruction, branch_target, pc, if_id_instr, if_id_pc, fetch_count;
  logic stall, branch_taken, if_id_valid, halted;
  modport master (
    input  instruction, stall, branch_taken, branch_target,
    output pc, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count
  );
  modport slave (
    output instruction, stall, branch_taken, branch_target,
    input  pc, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with PC, IF/ID register and fetch counter.
// Define FETCH_HALT_EN to stop fetching on opcode 4'hF until a branch redirects.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int MEM_BYTES = 128
) (
  input logic clk,
  input logic rst_n,
  fetch_unit_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1;
  localparam logic [15:0] PC_MASK = 16'(MEM_BYTES - 1) & 16'hFFFE;
  logic [1:0] state, fetch_state;
  logic [15:0] pc, if_id_instr, if_id_pc, fetch_count;
  logic if_id_valid, halted, halt_op, fetch;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] HALTED = 2'd2;
  assign halt_op = bus.instruction[15:12] == 4'hF;
  assign halted = state == HALTED;
  assign fetch_state = halt_op ? HALTED : RUN;
`else
  assign halt_op = 1'b0;
  assign halted = 1'b0;
  assign fetch_state = RUN;
`endif
  // a halt opcode is latched even under stall, since halt detect outranks stall
  assign fetch = state == RUN && (halt_op || !bus.stall);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (bus.branch_taken) begin
      state <= RUN;
      pc <= bus.branch_target & PC_MASK;
      if_id_valid <= 1'b0;
    end else if (fetch) begin
      state <= fetch_state;
      pc <= (pc + 16'd2) & PC_MASK;
      if_id_instr <= bus.instruction;
      if_id_pc <= pc;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 16'd1;
    end else begin
      if (state == IDLE) state <= RUN;
      if (state != RUN) if_id_valid <= 1'b0;
    end
  assign bus.pc = pc;
  assign bus.if_id_instr = if_id_instr;
  assign bus.if_id_pc = if_id_pc;
  assign bus.if_id_valid = if_id_valid;
  assign bus.halted = halted;
  assign bus.fetch_count = fetch_count;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset; SHALL be even.
REQ-002 Parameter MEM_BYTES, default 128: instruction memory size in bytes; power of two; PC SHALL stay within 0..MEM_BYTES-2.
REQ-003 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Instruction  input  16  combinational fetch data from instruction memory for the current PC.
REQ-006 Stall  input  1  decode stage cannot accept; SHALL hold PC and the IF/ID register.
REQ-007 BranchTaken  input  1  redirect request from the execute stage.
REQ-008 BranchTarget  input  16  redirect byte address; valid while BranchTaken=1.
REQ-009 PC  output  16  byte address driven to instruction memory.
REQ-010 IfIdInstr  output  16  registered instruction for decode.
REQ-011 IfIdPC  output  16  registered address of IfIdInstr.
REQ-012 IfIdValid  output  1  IfIdInstr holds a real instruction, not a bubble.
REQ-013 Halted  output  1  fetch stopped by a halt opcode (FETCH_HALT_EN only).
REQ-014 FetchCount  output  16  number of instructions delivered with IfIdValid=1; wraps at 16'hFFFF.

Function
REQ-015 States SHALL be IDLE, RUN and HALTED (HALTED exists only with FETCH_HALT_EN).
REQ-016 IDLE SHALL last exactly one cycle after reset release, perform no fetch, then go to RUN.
REQ-017 In RUN with no Stall and no BranchTaken:
- IfIdInstr<=Instruction, IfIdPC<=PC, IfIdValid<=1, FetchCount<=FetchCount+1.
- PC<=(PC+2) mod MEM_BYTES.
REQ-018 PC wrap-around: at PC=MEM_BYTES-2, the next PC SHALL be 0.
REQ-019 Stall=1 (no branch): PC, IfIdInstr, IfIdPC, IfIdValid and FetchCount SHALL hold their values.
REQ-020 BranchTaken=1: PC<=BranchTarget with bit 0 cleared, modulo MEM_BYTES; IfIdValid<=0 (bubble); IfIdInstr and IfIdPC hold.
REQ-021 BranchTaken SHALL override Stall in the same cycle.
REQ-022 Priority SHALL be reset > BranchTaken > halt detect > Stall > normal fetch.
REQ-023 Fetch latency: an instruction at address A SHALL appear on IfIdInstr one cycle after PC=A with no Stall.
REQ-024 In IDLE and HALTED, IfIdValid SHALL be 0 and PC SHALL hold, unless a branch occurs per REQ-028.

Reset
REQ-025 While Reset_n=0, the block SHALL asynchronously force:
- PC=RESET_PC, IfIdInstr=0, IfIdPC=0, IfIdValid=0, FetchCount=0.
- Halted=0, state=IDLE.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight fetch; the first fetch after release SHALL come from RESET_PC.

Configuration
REQ-027 Macro FETCH_HALT_EN defined: when RUN latches an instruction with bits [15:12]=4'hF, that instruction SHALL be delivered with IfIdValid=1.
- From the next cycle: state=HALTED, Halted=1, PC holds at the halt address+2.
REQ-028 With FETCH_HALT_EN, BranchTaken in HALTED SHALL perform REQ-020, clear Halted and return to RUN.
REQ-029 Without FETCH_HALT_EN:
- Opcode 4'hF SHALL be fetched like any other instruction.
- Halted SHALL be tied to 0 and the HALTED state SHALL not exist.

Verification
REQ-030 Reset then run with memory words 0x1111, 0x2222, 0x3333 at addresses 0, 2, 4 -> IfIdValid=0 for the IDLE cycle, then IfIdInstr=0x1111/IfIdPC=0, 0x2222/2, 0x3333/4 on consecutive cycles; FetchCount=3.
REQ-031 Stall=1 for 3 cycles at PC=6 -> PC stays 6, IfIdInstr and FetchCount frozen; fetch resumes at address 6 after Stall drops.
REQ-032 BranchTaken=1 with BranchTarget=0x0021 together with Stall=1 -> next cycle PC=0x20, IfIdValid=0; following cycle IfIdPC=0x20.
REQ-033 Free-run from PC=126 with MEM_BYTES=128 -> PC sequence 126, 0, 2; IfIdPC sequence 126 then 0.
REQ-034 FETCH_HALT_EN, word 0xF000 at address 8 -> IfIdInstr=0xF000 with IfIdValid=1, then Halted=1, PC=10 and IfIdValid=0 indefinitely; BranchTaken to 0x0004 -> Halted=0, fetch resumes at 4.
REQ-035 Reset_n pulsed low mid-run at PC=0x40 -> all outputs immediately take their reset values; after release, first fetch at RESET_PC.
